decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_if.sv | 25 ++
 rtl/decode_stage.sv | 83 ++++++++
 2 files changed

// File: rtl/decode_if.sv
// decode_if: instruction, issue and writeback signals of the decode stage
interface decode_if;
  logic [15:0] i_inst;
  logic        i_inst_valid;
  logic        o_inst_ready;
  logic [7:0]  o_data1;
  logic [7:0]  o_data2;
  logic [8:0]  o_aluOp;
  logic [2:0]  o_rd;
  logic        o_valid;
  logic        i_ready;
  logic        i_wb_en;
  logic [2:0]  i_wb_addr;
  logic [7:0]  i_wb_data;
  logic        o_err;
  logic [7:0]  o_issue_cnt;
  modport master (
    output i_inst, i_inst_valid, i_ready, i_wb_en, i_wb_addr, i_wb_data,
    input  o_inst_ready, o_data1, o_data2, o_aluOp, o_rd, o_valid, o_err, o_issue_cnt
  );
  modport slave (
    input  i_inst, i_inst_valid, i_ready, i_wb_en, i_wb_addr, i_wb_data,
    output o_inst_ready, o_data1, o_data2, o_aluOp, o_rd, o_valid, o_err, o_issue_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: decode, register file and pending scoreboard with 1-cycle issue.
// Define DECODE_BYPASS_EN to forward a same-cycle writeback into stall check and operand reads.
module decode_stage (
  input logic     i_clk,
  input logic     i_rst_n,
  decode_if.slave d
);
  logic [7:0] rf [8];
  logic [7:0] pend;
  logic [7:0] pend_chk;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic [7:0] wb_clr;
  logic [7:0] add_set;
  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [7:0] imm;
  logic       stall;
  logic       acc;
  logic       issue;
  logic       ldi;
  logic       ill;
  assign op  = d.i_inst[15:12];
  assign rd  = d.i_inst[11:9];
  assign rs1 = d.i_inst[8:6];
  assign rs2 = d.i_inst[5:3];
  assign imm = d.i_inst[7:0];
  assign wb_clr = d.i_wb_en ? 8'd1 << d.i_wb_addr : 8'd0;
`ifdef DECODE_BYPASS_EN
  assign pend_chk = pend & ~wb_clr;
  assign rd1 = (d.i_wb_en && d.i_wb_addr == rs1) ? d.i_wb_data : rf[rs1];
  assign rd2 = (d.i_wb_en && d.i_wb_addr == rs2) ? d.i_wb_data : rf[rs2];
`else
  assign pend_chk = pend;
  assign rd1 = rf[rs1];
  assign rd2 = rf[rs2];
`endif
  always_comb begin
    stall = (op == 4'd1) ? (pend_chk[rs1] | pend_chk[rs2] | pend_chk[rd]) :
            (op == 4'd2) ? pend_chk[rs1] :
            (op == 4'd3) ? pend_chk[rd] : 1'b0;
    d.o_inst_ready = ~stall & (~d.o_valid | d.i_ready);
    acc     = d.i_inst_valid & d.o_inst_ready;
    issue   = acc & (op < 4'd3);
    ldi     = acc & (op == 4'd3);
    ill     = acc & (op[3:2] != 2'b00);
    add_set = (acc && op == 4'd1) ? 8'd1 << rd : 8'd0;
  end
  // LDI is written after the writeback so it wins on a shared target
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (d.i_wb_en) rf[d.i_wb_addr] <= d.i_wb_data;
      if (ldi) rf[rd] <= imm;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      pend          <= '0;
      d.o_valid     <= 1'b0;
      d.o_data1     <= '0;
      d.o_data2     <= '0;
      d.o_aluOp     <= '0;
      d.o_rd        <= '0;
      d.o_err       <= 1'b0;
      d.o_issue_cnt <= '0;
    end else begin
      pend <= (pend & ~wb_clr) | add_set;
      if (ill) d.o_err <= 1'b1;
      if (issue) begin
        d.o_valid     <= 1'b1;
        d.o_data1     <= rd1;
        d.o_data2     <= (op == 4'd1) ? rd2 : 8'd0;
        d.o_aluOp     <= {7'd0, op[1:0]};
        d.o_rd        <= rd;
        d.o_issue_cnt <= d.o_issue_cnt + 8'd1;
      end else if (d.i_ready) begin
        d.o_valid <= 1'b0;
      end
    end
endmodule
